// File: rtl/trace_pkg.sv
// Shared definitions for the commit trace buffer: state encoding and the
// layout of one stored trace entry.
package trace_pkg;

  localparam int ENTRY_W   = 103;
  localparam int PC_LSB    = 0;
  localparam int INSTR_LSB = 32;
  localparam int WDATA_LSB = 64;
  localparam int WREG_LSB  = 96;
  localparam int RW_BIT    = 101;
  localparam int MW_BIT    = 102;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } trace_state_e;

endpackage

// File: rtl/trace_fifo_mem.sv
// First-word-fall-through entry store. A push into a full FIFO is taken only
// when a pop happens in the same cycle; the head output holds its last value
// while the FIFO is empty.
module trace_fifo_mem
  import trace_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_push,
  input  logic [ENTRY_W-1:0] i_wdata,
  input  logic               i_ready,
  output logic               o_valid,
  output logic               o_full,
  output logic               o_pop,
  output logic [LW-1:0]      o_level,
  output logic [ENTRY_W-1:0] o_rdata
);

  logic [ENTRY_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]      r_wptr;
  logic [AW-1:0]      r_rptr;
  logic [LW-1:0]      r_level;
  logic [ENTRY_W-1:0] r_hold;

  logic               w_valid;
  logic               w_full;
  logic               w_pop;
  logic               w_push_ok;
  logic [ENTRY_W-1:0] w_rdata;

  assign w_valid   = (r_level != '0);
  assign w_full    = (r_level == LW'(DEPTH));
  assign w_pop     = w_valid && i_ready;
  assign w_push_ok = i_push && (!w_full || w_pop);
  assign w_rdata   = w_valid ? r_mem[r_rptr] : r_hold;

  // Storage write; storage itself needs no reset since level gates reads.
  always_ff @(posedge clk) begin
    if (reset && w_push_ok) r_mem[r_wptr] <= i_wdata;
  end

  // Pointers, level and the held head value.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_hold  <= '0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + AW'(1);
      if (w_pop)     r_rptr <= r_rptr + AW'(1);
      case ({w_push_ok, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
      r_hold <= w_rdata;
    end
  end

  assign o_valid = w_valid;
  assign o_full  = w_full;
  assign o_pop   = w_pop;
  assign o_level = r_level;
  assign o_rdata = w_rdata;

endmodule

// File: rtl/commit_trace_buffer.sv
// Commit trace capture: arms on request, triggers on a PC match (or the first
// commit), pushes retired-instruction records into a FWFT FIFO and stops after
// an optional entry budget. Dropped pushes are counted and flagged.
//
// state    | meaning
// ST_IDLE  | nothing captured, waiting for arm
// ST_ARMED | waiting for the trigger commit
// ST_CAPTURE | every commit attempts a push
// ST_DONE  | budget reached, commits ignored until re-armed
module commit_trace_buffer
  import trace_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int LW = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_arm,
  input  logic          i_trig_en,
  input  logic [31:0]   i_trig_pc,
  input  logic [7:0]    i_stop_count,
  input  logic          i_commit_valid,
  input  logic [31:0]   i_pc,
  input  logic [31:0]   i_instr,
  input  logic          i_reg_write,
  input  logic          i_mem_write,
  input  logic [4:0]    i_write_reg,
  input  logic [31:0]   i_write_data,
  output logic          o_out_valid,
  input  logic          i_out_ready,
  output logic [31:0]   o_out_pc,
  output logic [31:0]   o_out_instr,
  output logic [31:0]   o_out_wdata,
  output logic [4:0]    o_out_wreg,
  output logic          o_out_rw,
  output logic          o_out_mw,
  output logic [1:0]    o_state,
  output logic [LW-1:0] o_level,
  output logic [15:0]   o_drop_cnt,
  output logic          o_overflow
);

  trace_state_e r_state;
  trace_state_e w_next;
  logic [7:0]   r_cnt;
  logic [7:0]   w_cnt_next;
  logic [7:0]   w_cnt_inc;
  logic         w_hit_stop;
  logic         w_trig_hit;
  logic         w_push_req;
  logic [15:0]  r_drop_cnt;
  logic         r_overflow;

  logic [ENTRY_W-1:0] w_entry;
  logic [ENTRY_W-1:0] w_head;
  logic               w_full;
  logic               w_pop;
  logic               w_drop;

  assign w_cnt_inc  = r_cnt + 8'd1;
  assign w_hit_stop = (i_stop_count != 8'd0) && (w_cnt_inc == i_stop_count);
  assign w_trig_hit = i_commit_valid && (!i_trig_en || (i_pc == i_trig_pc));

  // Pack the retired-instruction record into one entry.
  always_comb begin
    w_entry = '0;
    w_entry[PC_LSB    +: 32] = i_pc;
    w_entry[INSTR_LSB +: 32] = i_instr;
    w_entry[WDATA_LSB +: 32] = i_write_data;
    w_entry[WREG_LSB  +: 5]  = i_write_reg;
    w_entry[RW_BIT]          = i_reg_write;
    w_entry[MW_BIT]          = i_mem_write;
  end

  // State and capture-count registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= 8'd0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Next state, push request and count update; arm overrides everything.
  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    w_push_req = 1'b0;
    if (i_arm) begin
      w_next     = ST_ARMED;
      w_cnt_next = 8'd0;
    end else begin
      case (r_state)
        ST_ARMED: begin
          if (w_trig_hit) begin
            w_push_req = 1'b1;
            w_cnt_next = w_cnt_inc;
            w_next     = w_hit_stop ? ST_DONE : ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          if (i_commit_valid) begin
            w_push_req = 1'b1;
            w_cnt_next = w_cnt_inc;
            if (w_hit_stop) w_next = ST_DONE;
          end
        end
        default: ;
      endcase
    end
  end

  trace_fifo_mem #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push_req),
    .i_wdata (w_entry),
    .i_ready (i_out_ready),
    .o_valid (o_out_valid),
    .o_full  (w_full),
    .o_pop   (w_pop),
    .o_level (o_level),
    .o_rdata (w_head)
  );

  assign w_drop = w_push_req && w_full && !w_pop;

  // Saturating drop counter and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_drop_cnt <= 16'd0;
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      if (r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
      r_overflow <= 1'b1;
    end
  end

  assign o_state     = r_state;
  assign o_drop_cnt  = r_drop_cnt;
  assign o_overflow  = r_overflow;
  assign o_out_pc    = w_head[PC_LSB    +: 32];
  assign o_out_instr = w_head[INSTR_LSB +: 32];
  assign o_out_wdata = w_head[WDATA_LSB +: 32];
  assign o_out_wreg  = w_head[WREG_LSB  +: 5];
  assign o_out_rw    = w_head[RW_BIT];
  assign o_out_mw    = w_head[MW_BIT];

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Directed bench for commit_trace_buffer with hand-computed expectations.
module tb_commit_trace_buffer;

  localparam int DEPTH = 16;
  localparam int LW = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          i_arm = 1'b0;
  logic          i_trig_en = 1'b0;
  logic [31:0]   i_trig_pc = '0;
  logic [7:0]    i_stop_count = '0;
  logic          i_commit_valid = 1'b0;
  logic [31:0]   i_pc = '0;
  logic [31:0]   i_instr = '0;
  logic          i_reg_write = 1'b0;
  logic          i_mem_write = 1'b0;
  logic [4:0]    i_write_reg = '0;
  logic [31:0]   i_write_data = '0;
  logic          o_out_valid;
  logic          i_out_ready = 1'b0;
  logic [31:0]   o_out_pc;
  logic [31:0]   o_out_instr;
  logic [31:0]   o_out_wdata;
  logic [4:0]    o_out_wreg;
  logic          o_out_rw;
  logic          o_out_mw;
  logic [1:0]    o_state;
  logic [LW-1:0] o_level;
  logic [15:0]   o_drop_cnt;
  logic          o_overflow;

  int n_vec = 0;
  int n_err = 0;

  commit_trace_buffer #(.DEPTH(DEPTH)) dut (
    .clk            (clk),
    .reset          (reset),
    .i_arm          (i_arm),
    .i_trig_en      (i_trig_en),
    .i_trig_pc      (i_trig_pc),
    .i_stop_count   (i_stop_count),
    .i_commit_valid (i_commit_valid),
    .i_pc           (i_pc),
    .i_instr        (i_instr),
    .i_reg_write    (i_reg_write),
    .i_mem_write    (i_mem_write),
    .i_write_reg    (i_write_reg),
    .i_write_data   (i_write_data),
    .o_out_valid    (o_out_valid),
    .i_out_ready    (i_out_ready),
    .o_out_pc       (o_out_pc),
    .o_out_instr    (o_out_instr),
    .o_out_wdata    (o_out_wdata),
    .o_out_wreg     (o_out_wreg),
    .o_out_rw       (o_out_rw),
    .o_out_mw       (o_out_mw),
    .o_state        (o_state),
    .o_level        (o_level),
    .o_drop_cnt     (o_drop_cnt),
    .o_overflow     (o_overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_arm();
    i_arm = 1'b1;
    step();
    i_arm = 1'b0;
  endtask

  // One retired instruction; the other fields are derived from pc.
  task automatic commit(input logic [31:0] pc);
    i_commit_valid = 1'b1;
    i_pc         = pc;
    i_instr      = pc ^ 32'hA5A5_0000;
    i_write_data = pc + 32'd1;
    i_write_reg  = pc[6:2];
    i_reg_write  = pc[2];
    i_mem_write  = pc[3];
    step();
    i_commit_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
  endtask

  initial begin
    // Reset values
    do_reset();
    chk("rst_state", 32'(o_state), 32'd0);
    chk("rst_level", 32'(o_level), 32'd0);
    chk("rst_valid", 32'(o_out_valid), 32'd0);
    chk("rst_drop", 32'(o_drop_cnt), 32'd0);
    chk("rst_ovf", 32'(o_overflow), 32'd0);
    chk("rst_pc", o_out_pc, 32'd0);

    // Immediate trigger, streaming consumer
    i_trig_en = 1'b0;
    i_stop_count = 8'd0;
    i_out_ready = 1'b1;
    do_arm();
    chk("arm_state", 32'(o_state), 32'd1);
    for (int k = 0; k < 5; k++) begin
      commit(32'(k * 4));
      chk("s1_valid", 32'(o_out_valid), 32'd1);
      chk("s1_pc", o_out_pc, 32'(k * 4));
      if (k == 0) chk("s1_trig_state", 32'(o_state), 32'd2);
      if (k == 3) begin
        chk("s1_instr", o_out_instr, 32'hA5A5_000C);
        chk("s1_wdata", o_out_wdata, 32'h0000_000D);
        chk("s1_wreg", 32'(o_out_wreg), 32'd3);
        chk("s1_rw", 32'(o_out_rw), 32'd1);
        chk("s1_mw", 32'(o_out_mw), 32'd1);
      end
    end
    step();
    chk("s1_level", 32'(o_level), 32'd0);
    chk("s1_empty", 32'(o_out_valid), 32'd0);
    chk("s1_hold_pc", o_out_pc, 32'h10);
    chk("s1_drop", 32'(o_drop_cnt), 32'd0);
    chk("s1_state", 32'(o_state), 32'd2);

    // PC-match trigger
    do_reset();
    i_trig_en = 1'b1;
    i_trig_pc = 32'h14;
    i_out_ready = 1'b0;
    do_arm();
    for (int k = 0; k <= 8; k++) begin
      commit(32'(k * 4));
      if (k == 4) chk("s2_pre_trig", 32'(o_state), 32'd1);
      if (k == 5) chk("s2_trig", 32'(o_state), 32'd2);
    end
    chk("s2_level", 32'(o_level), 32'd4);
    chk("s2_head", o_out_pc, 32'h14);

    // Overflow, then push with simultaneous pop at full
    do_reset();
    i_trig_en = 1'b0;
    i_out_ready = 1'b0;
    do_arm();
    for (int k = 0; k < 20; k++) commit(32'h100 + 32'(k * 4));
    chk("s3_level", 32'(o_level), 32'd16);
    chk("s3_drop", 32'(o_drop_cnt), 32'd4);
    chk("s3_ovf", 32'(o_overflow), 32'd1);
    chk("s3_head", o_out_pc, 32'h100);
    i_out_ready = 1'b1;
    commit(32'h200);
    chk("s3_full_lvl", 32'(o_level), 32'd16);
    chk("s3_full_drop", 32'(o_drop_cnt), 32'd4);
    chk("s3_full_head", o_out_pc, 32'h104);
    for (int k = 0; k < 16; k++) begin
      chk("s3_drain", o_out_pc, (k < 15) ? 32'h104 + 32'(k * 4) : 32'h200);
      step();
    end
    chk("s3_drained", 32'(o_level), 32'd0);
    chk("s3_ovf_sticky", 32'(o_overflow), 32'd1);

    // Stop count and re-arm
    i_out_ready = 1'b0;
    i_stop_count = 8'd3;
    do_arm();
    chk("s4_keep_drop", 32'(o_drop_cnt), 32'd4);
    for (int k = 0; k < 6; k++) begin
      commit(32'h300 + 32'(k * 4));
      if (k == 1) chk("s4_cap", 32'(o_state), 32'd2);
      if (k == 2) chk("s4_done", 32'(o_state), 32'd3);
    end
    chk("s4_level", 32'(o_level), 32'd3);
    do_arm();
    chk("s4_rearm", 32'(o_state), 32'd1);
    chk("s4_keep_lvl", 32'(o_level), 32'd3);
    commit(32'h400);
    commit(32'h404);
    chk("s4_cnt_cleared", 32'(o_state), 32'd2);
    commit(32'h408);
    chk("s4_done2", 32'(o_state), 32'd3);
    chk("s4_level2", 32'(o_level), 32'd6);

    // Reset mid-capture
    i_stop_count = 8'd0;
    do_arm();
    commit(32'h500);
    chk("s5_level7", 32'(o_level), 32'd7);
    chk("s5_cap", 32'(o_state), 32'd2);
    reset = 1'b0;
    i_out_ready = 1'b1;
    i_commit_valid = 1'b1;
    step();
    i_commit_valid = 1'b0;
    reset = 1'b1;
    chk("s5_level", 32'(o_level), 32'd0);
    chk("s5_valid", 32'(o_out_valid), 32'd0);
    chk("s5_state", 32'(o_state), 32'd0);
    chk("s5_drop", 32'(o_drop_cnt), 32'd0);
    chk("s5_ovf", 32'(o_overflow), 32'd0);
    chk("s5_pc", o_out_pc, 32'd0);
    step();
    chk("s5_idle_level", 32'(o_level), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/commit_trace_buffer.md
COMMIT_TRACE_BUFFER -- requirements
Module: commit_trace_buffer

Interface
REQ-001 Parameter DEPTH, default 16, number of trace entries; SHALL be a power of two, 2..256.
REQ-002 clk  input  1  clock; all state SHALL change on rising edge only.
REQ-003 reset  input  1  reset, synchronous, active-low.
REQ-004 arm  input  1  single-cycle pulse: clear capture count, enter ARMED.
REQ-005 trig_en  input  1  1 = wait for trig_pc match; 0 = first commit triggers.
REQ-006 trig_pc  input  32  trigger PC.
REQ-007 stop_count  input  8  entries to capture before DONE; 0 = unlimited.
REQ-008 commit_valid  input  1  core retired one instruction this cycle.
REQ-009 pc, instr  input  32 each  retired PC, instruction word.
REQ-010 reg_write, mem_write  input  1 each  core write enables.
REQ-011 write_reg  input  5  destination register; write_data  input  32  register write value.
REQ-012 out_valid  output  1  head entry available; out_ready  input  1  consumer accepts head.
REQ-013 out_pc, out_instr, out_wdata  output  32 each; out_wreg  output  5; out_rw, out_mw  output  1 each: head entry fields.
REQ-014 state  output  2  IDLE=0, ARMED=1, CAPTURE=2, DONE=3.
REQ-015 level  output  clog2(DEPTH)+1  entries stored; drop_cnt  output  16  dropped commits; overflow  output  1  sticky drop flag.

Function
REQ-016 IDLE: no capture; arm -> ARMED, capture count cleared to 0.
REQ-017 ARMED: commit_valid && (!trig_en || pc==trig_pc) -> CAPTURE; that triggering commit SHALL itself be captured.
REQ-018 CAPTURE: every commit_valid cycle produces one push attempt of {pc, instr, write_reg, write_data, reg_write, mem_write}; capture count increments on each attempt, accepted or dropped.
REQ-019 CAPTURE -> DONE on the edge where capture count reaches stop_count (stop_count != 0); further commits ignored.
REQ-020 arm in ARMED, CAPTURE or DONE -> ARMED with count cleared; FIFO contents, drop_cnt, overflow retained.
REQ-021 FIFO is first-word-fall-through: out_valid = (level != 0); head fields SHALL be valid whenever out_valid=1.
REQ-022 Pop occurs when out_valid && out_ready; entry pushed at edge N SHALL be visible at head after edge N when FIFO was empty (1-cycle latency).
REQ-023 Push when full SHALL be accepted only if a pop occurs the same cycle; otherwise entry dropped, drop_cnt += 1 (saturates at 0xFFFF), overflow set to 1.
REQ-024 Simultaneous push and pop: level unchanged; empty FIFO with push+out_ready: no pop, level becomes 1.
REQ-025 Read/write pointers SHALL wrap modulo DEPTH; level SHALL reach exactly DEPTH when full.
REQ-026 Head field outputs SHALL hold last value (or zero after reset) when out_valid=0; consumers SHALL ignore them.
REQ-027 overflow clears only by reset.

Reset
REQ-028 reset=0 at a rising edge SHALL set state=IDLE, pointers, level, capture count, drop_cnt=0, overflow=0, all out_* fields=0, out_valid=0.
REQ-029 Reset mid-capture SHALL discard all stored entries; no push or pop occurs in the reset cycle.

Structure
REQ-030 Shared package trace_pkg SHALL hold state encoding constants, entry width constant (103 bits) and field bit offsets.
REQ-031 Storage and pointers SHALL be one sub-module trace_fifo_mem (DEPTH x 103 regs, push/pop/full/empty/level); FSM, counters and trigger compare live in commit_trace_buffer.

Verification
REQ-032 trig_en=0, stop_count=0, arm, 5 commits pc=0x00..0x10, out_ready=1 -> 5 entries emitted in order, drop_cnt=0, state=CAPTURE.
REQ-033 trig_en=1, trig_pc=0x14, commits pc 0x00,0x04..0x20 -> first entry out_pc=0x14, ARMED->CAPTURE on that cycle.
REQ-034 DEPTH=16, out_ready=0, 20 commits -> level=16, drop_cnt=4, overflow=1; then out_ready=1 -> 16 entries, first out_pc = first commit.
REQ-035 Full FIFO, commit with out_ready=1 same cycle -> push accepted, level stays 16, drop_cnt unchanged.
REQ-036 stop_count=3, 6 commits -> exactly 3 entries, state=DONE after 3rd; arm -> ARMED, count 0.
REQ-037 Reset asserted with level=7 in CAPTURE -> next cycle level=0, out_valid=0, state=IDLE, drop_cnt=0.
